rv_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I core.
- Decodes the latched opcode and sequences FETCH→DECODE→EXEC→MEM→WB.
- Generates the 2-bit select codes consumed by the datapath 4:1 muxes, plus register/memory write enables.
- Handshakes with instruction and data memory through req/ready pairs and counts retired instructions.

---
 rtl/rv_ctrl_pkg.sv | 61 ++++++
 rtl/rv_mem_wait_timer.sv | 43 ++++
 rtl/rv_multicycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// ============================================================================
// Module   : rv_ctrl_pkg
// Purpose  : State encoding, opcodes, datapath select codes and trap causes
//            shared by the multi-cycle control FSM and datapath muxes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_ialu   = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;

  localparam logic [1:0] c_pc_plus4  = 2'b00;
  localparam logic [1:0] c_pc_branch = 2'b01;
  localparam logic [1:0] c_pc_alu    = 2'b10;

  localparam logic [1:0] c_alua_rs1  = 2'b00;
  localparam logic [1:0] c_alua_pc   = 2'b01;
  localparam logic [1:0] c_alua_zero = 2'b10;

  localparam logic [1:0] c_alub_rs2  = 2'b00;
  localparam logic [1:0] c_alub_imm  = 2'b01;
  localparam logic [1:0] c_alub_four = 2'b10;

  localparam logic [1:0] c_wb_alu    = 2'b00;
  localparam logic [1:0] c_wb_load   = 2'b10;
  localparam logic [1:0] c_wb_link   = 2'b11;

  localparam logic [1:0] c_cause_none    = 2'b00;
  localparam logic [1:0] c_cause_illegal = 2'b01;
  localparam logic [1:0] c_cause_imem    = 2'b10;
  localparam logic [1:0] c_cause_dmem    = 2'b11;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      c_op_rtype, c_op_ialu, c_op_load, c_op_store, c_op_branch,
      c_op_jal, c_op_jalr, c_op_lui, c_op_auipc: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_mem_wait_timer.sv
// ============================================================================
// Module   : rv_mem_wait_timer
// Purpose  : Counts cycles spent waiting on a memory ready and flags expiry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rv_mem_wait_timer
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam int unsigned c_cnt_w   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned c_lim_int = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [c_cnt_w-1:0] c_limit  = c_cnt_w'(c_lim_int);
  localparam logic               c_enable = (TIMEOUT_CYCLES != 0);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (clr)
      r_cnt <= '0;
    else if (active && !ready)
      r_cnt <= r_cnt + 1'b1;
  end

  // Fires on the last permitted wait cycle so the FSM leaves on the next edge;
  // a ready in that same cycle suppresses it.
  assign expired = c_enable && active && !ready && (r_cnt == c_limit);

endmodule

`default_nettype wire

// File: rtl/rv_multicycle_ctrl.sv
// ============================================================================
// Module   : rv_multicycle_ctrl
// Purpose  : RV32I multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Revision : 1.0
// ============================================================================
`default_nettype none

module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned RET_CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 branch_taken,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_re,
  output logic                 dmem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 rf_we,
  output logic [1:0]           pc_sel,
  output logic [1:0]           alu_a_sel,
  output logic [1:0]           alu_b_sel,
  output logic [1:0]           wb_sel,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [RET_CNT_W-1:0] retired
);

  state_t               r_state;
  state_t               w_next;
  logic [6:0]           r_opcode;
  logic [1:0]           r_cause;
  logic [1:0]           w_new_cause;
  logic [RET_CNT_W-1:0] r_retired;
  logic                 w_retire;
  logic                 w_expired;
  logic                 w_wait_active;
  logic                 w_wait_ready;
  logic                 w_is_load;
  logic                 w_is_store;
  logic                 w_unused;

  assign w_unused      = ^instr[31:7];
  assign w_is_load     = (r_opcode == c_op_load);
  assign w_is_store    = (r_opcode == c_op_store);
  assign w_wait_active = (r_state == FETCH) || (r_state == MEM);
  assign w_wait_ready  = (r_state == FETCH) ? imem_ready : dmem_ready;

  rv_mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_next != r_state),
    .active  (w_wait_active),
    .ready   (w_wait_ready),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_opcode  <= 7'd0;
      r_cause   <= c_cause_none;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && imem_ready)
        r_opcode <= instr[6:0];
      if (w_next == TRAP && r_state != TRAP)
        r_cause <= w_new_cause;
      if (w_retire)
        r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_retire    = 1'b0;
    w_new_cause = c_cause_none;
    case (r_state)
      FETCH: begin
        if (imem_ready) begin
          w_next = DECODE;
        end else if (w_expired) begin
          w_next      = TRAP;
          w_new_cause = c_cause_imem;
        end
      end
      DECODE: begin
        if (is_legal_opcode(r_opcode)) begin
          w_next = EXEC;
        end else begin
          w_next      = TRAP;
          w_new_cause = c_cause_illegal;
        end
      end
      EXEC: begin
        if (r_opcode == c_op_branch) begin
          w_next   = FETCH;
          w_retire = 1'b1;
        end else if (w_is_load || w_is_store) begin
          w_next = MEM;
        end else begin
          w_next = WB;
        end
      end
      MEM: begin
        if (dmem_ready) begin
          w_next   = w_is_store ? FETCH : WB;
          w_retire = w_is_store;
        end else if (w_expired) begin
          w_next      = TRAP;
          w_new_cause = c_cause_dmem;
        end
      end
      WB: begin
        w_next   = FETCH;
        w_retire = 1'b1;
      end
      TRAP:    w_next = TRAP;
      default: w_next = FETCH;
    endcase
  end

  // Outputs are forced quiet while rst_n is low so no request escapes during reset.
  always_comb begin
    imem_req  = 1'b0;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    pc_sel    = c_pc_plus4;
    alu_a_sel = c_alua_rs1;
    alu_b_sel = c_alub_rs2;
    wb_sel    = c_wb_alu;
    if (rst_n) begin
      case (r_state)
        FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
          pc_we    = imem_ready;
        end
        EXEC: begin
          case (r_opcode)
            c_op_ialu, c_op_load, c_op_store: alu_b_sel = c_alub_imm;
            c_op_jalr: begin
              alu_b_sel = c_alub_imm;
              pc_we     = 1'b1;
              pc_sel    = c_pc_alu;
            end
            c_op_auipc: begin
              alu_a_sel = c_alua_pc;
              alu_b_sel = c_alub_imm;
            end
            c_op_lui: begin
              alu_a_sel = c_alua_zero;
              alu_b_sel = c_alub_imm;
            end
            c_op_branch: begin
              pc_we  = branch_taken;
              pc_sel = branch_taken ? c_pc_branch : c_pc_plus4;
            end
            c_op_jal: begin
              pc_we  = 1'b1;
              pc_sel = c_pc_branch;
            end
            default: ;
          endcase
        end
        MEM: begin
          dmem_re   = w_is_load;
          dmem_we   = w_is_store;
          alu_b_sel = c_alub_imm;
        end
        WB: begin
          rf_we = 1'b1;
          if (w_is_load)
            wb_sel = c_wb_load;
          else if (r_opcode == c_op_jal || r_opcode == c_op_jalr)
            wb_sel = c_wb_link;
        end
        default: ;
      endcase
    end
  end

  assign trap       = (r_state == TRAP);
  assign trap_cause = r_cause;
  assign retired    = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_rv_multicycle_ctrl
// Purpose  : Directed self-checking bench for rv_multicycle_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        branch_taken = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_re, dmem_we, ir_we, pc_we, rf_we, trap;
  logic [1:0]  pc_sel, alu_a_sel, alu_b_sel, wb_sel, trap_cause;
  logic [31:0] retired;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_ret = 32'd0;
  logic [16:0] want;
  logic [16:0] outs;

  // {imem_req,dmem_re,dmem_we,ir_we,pc_we,rf_we}_pc_alua_alub_wb_trap_cause
  localparam logic [16:0] c_idle  = 17'b000000_00_00_00_00_0_00;
  localparam logic [16:0] c_fetch = 17'b100110_00_00_00_00_0_00;
  localparam logic [16:0] c_req   = 17'b100000_00_00_00_00_0_00;

  assign outs = {imem_req, dmem_re, dmem_we, ir_we, pc_we, rf_we,
                 pc_sel, alu_a_sel, alu_b_sel, wb_sel, trap, trap_cause};

  always #5 clk = ~clk;

  rv_multicycle_ctrl #(
    .TIMEOUT_CYCLES (8),
    .RET_CNT_W      (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .dmem_re      (dmem_re),
    .dmem_we      (dmem_we),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .rf_we        (rf_we),
    .pc_sel       (pc_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .wb_sel       (wb_sel),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .retired      (retired)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    imem_ready = 1'b1;
    #1;
    total++; if (outs !== c_idle) begin bad++; $display("FAIL reset_outs got=%b want=%b", outs, c_idle); end
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_retired got=%0d want=0", retired); end
    imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ret = 32'd0;
    #1;
  endtask

  task automatic test_reset;
    #2;
    do_reset();
    total++; if (outs !== c_req) begin bad++; $display("FAIL reset_fetch got=%b want=%b", outs, c_req); end
  endtask

  task automatic test_addi;
    instr = 32'h00500093; imem_ready = 1'b1; #1;
    total++; if (outs !== c_fetch) begin bad++; $display("FAIL addi_fetch got=%b want=%b", outs, c_fetch); end
    tick(); imem_ready = 1'b0; #1;
    total++; if (outs !== c_idle) begin bad++; $display("FAIL addi_decode got=%b want=%b", outs, c_idle); end
    tick(); #1; want = 17'b000000_00_00_01_00_0_00;
    total++; if (outs !== want) begin bad++; $display("FAIL addi_exec got=%b want=%b", outs, want); end
    tick(); #1; want = 17'b000001_00_00_00_00_0_00;
    total++; if (outs !== want) begin bad++; $display("FAIL addi_wb got=%b want=%b", outs, want); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL addi_wb_retired got=%0d want=%0d", retired, exp_ret); end
    tick(); exp_ret++; #1;
    total++; if (outs !== c_req) begin bad++; $display("FAIL addi_next_fetch got=%b want=%b", outs, c_req); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL addi_retired got=%0d want=%0d", retired, exp_ret); end
  endtask

  task automatic test_lw;
    instr = 32'h0000A103; imem_ready = 1'b1; #1;
    total++; if (outs !== c_fetch) begin bad++; $display("FAIL lw_fetch got=%b want=%b", outs, c_fetch); end
    tick(); imem_ready = 1'b0; #1;
    total++; if (outs !== c_idle) begin bad++; $display("FAIL lw_decode got=%b want=%b", outs, c_idle); end
    tick(); #1; want = 17'b000000_00_00_01_00_0_00;
    total++; if (outs !== want) begin bad++; $display("FAIL lw_exec got=%b want=%b", outs, want); end
    tick();
    want = 17'b010000_00_00_01_00_0_00;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3); #1;
      total++; if (outs !== want) begin bad++; $display("FAIL lw_mem%0d got=%b want=%b", i, outs, want); end
      tick();
    end
    dmem_ready = 1'b0; #1; want = 17'b000001_00_00_00_10_0_00;
    total++; if (outs !== want) begin bad++; $display("FAIL lw_wb got=%b want=%b", outs, want); end
    tick(); exp_ret++; #1;
    total++; if (outs !== c_req) begin bad++; $display("FAIL lw_next_fetch got=%b want=%b", outs, c_req); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL lw_retired got=%0d want=%0d", retired, exp_ret); end
  endtask

  task automatic test_branch;
    for (int t = 1; t >= 0; t--) begin
      instr = 32'h00208463; imem_ready = 1'b1; #1;
      total++; if (outs !== c_fetch) begin bad++; $display("FAIL beq%0d_fetch got=%b want=%b", t, outs, c_fetch); end
      tick(); imem_ready = 1'b0; #1;
      total++; if (outs !== c_idle) begin bad++; $display("FAIL beq%0d_decode got=%b want=%b", t, outs, c_idle); end
      tick(); branch_taken = t[0]; #1;
      want = t[0] ? 17'b000010_01_00_00_00_0_00 : c_idle;
      total++; if (outs !== want) begin bad++; $display("FAIL beq%0d_exec got=%b want=%b", t, outs, want); end
      tick(); branch_taken = 1'b0; exp_ret++; #1;
      total++; if (outs !== c_req) begin bad++; $display("FAIL beq%0d_next_fetch got=%b want=%b", t, outs, c_req); end
      total++; if (retired !== exp_ret) begin bad++; $display("FAIL beq%0d_retired got=%0d want=%0d", t, retired, exp_ret); end
    end
  endtask

  task automatic test_jal;
    instr = 32'h008000EF; imem_ready = 1'b1; #1;
    total++; if (outs !== c_fetch) begin bad++; $display("FAIL jal_fetch got=%b want=%b", outs, c_fetch); end
    tick(); imem_ready = 1'b0; #1;
    tick(); #1; want = 17'b000010_01_00_00_00_0_00;
    total++; if (outs !== want) begin bad++; $display("FAIL jal_exec got=%b want=%b", outs, want); end
    tick(); #1; want = 17'b000001_00_00_00_11_0_00;
    total++; if (outs !== want) begin bad++; $display("FAIL jal_wb got=%b want=%b", outs, want); end
    tick(); exp_ret++; #1;
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL jal_retired got=%0d want=%0d", retired, exp_ret); end
  endtask

  task automatic test_store;
    instr = 32'h0020A023; imem_ready = 1'b1; #1;
    tick(); imem_ready = 1'b0; #1;
    tick(); #1; want = 17'b000000_00_00_01_00_0_00;
    total++; if (outs !== want) begin bad++; $display("FAIL sw_exec got=%b want=%b", outs, want); end
    tick(); dmem_ready = 1'b1; #1; want = 17'b001000_00_00_01_00_0_00;
    total++; if (outs !== want) begin bad++; $display("FAIL sw_mem got=%b want=%b", outs, want); end
    tick(); dmem_ready = 1'b0; exp_ret++; #1;
    total++; if (outs !== c_req) begin bad++; $display("FAIL sw_next_fetch got=%b want=%b", outs, c_req); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL sw_retired got=%0d want=%0d", retired, exp_ret); end
  endtask

  task automatic test_lui;
    instr = 32'h123450B7; imem_ready = 1'b1; #1;
    tick(); imem_ready = 1'b0; #1;
    tick(); #1; want = 17'b000000_00_10_01_00_0_00;
    total++; if (outs !== want) begin bad++; $display("FAIL lui_exec got=%b want=%b", outs, want); end
    tick(); #1; want = 17'b000001_00_00_00_00_0_00;
    total++; if (outs !== want) begin bad++; $display("FAIL lui_wb got=%b want=%b", outs, want); end
    tick(); exp_ret++; #1;
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL lui_retired got=%0d want=%0d", retired, exp_ret); end
  endtask

  task automatic test_fetch_limit_ready;
    for (int i = 0; i < 7; i++) begin
      imem_ready = 1'b0; #1;
      total++; if (outs !== c_req) begin bad++; $display("FAIL limit_wait%0d got=%b want=%b", i, outs, c_req); end
      tick();
    end
    instr = 32'h00500093; imem_ready = 1'b1; #1;
    total++; if (outs !== c_fetch) begin bad++; $display("FAIL limit_fetch got=%b want=%b", outs, c_fetch); end
    tick(); imem_ready = 1'b0; #1;
    total++; if (outs !== c_idle) begin bad++; $display("FAIL limit_decode got=%b want=%b", outs, c_idle); end
    tick(); tick(); #1; want = 17'b000001_00_00_00_00_0_00;
    total++; if (outs !== want) begin bad++; $display("FAIL limit_wb got=%b want=%b", outs, want); end
    tick(); exp_ret++; #1;
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL limit_retired got=%0d want=%0d", retired, exp_ret); end
  endtask

  task automatic test_dmem_timeout;
    instr = 32'h0000A103; imem_ready = 1'b1; #1;
    tick(); imem_ready = 1'b0; #1;
    tick(); tick();
    want = 17'b010000_00_00_01_00_0_00;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++; if (outs !== want) begin bad++; $display("FAIL dto_mem%0d got=%b want=%b", i, outs, want); end
      tick();
    end
    #1; want = 17'b000000_00_00_00_00_1_11;
    total++; if (outs !== want) begin bad++; $display("FAIL dto_trap got=%b want=%b", outs, want); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL dto_retired got=%0d want=%0d", retired, exp_ret); end
    do_reset();
  endtask

  task automatic test_illegal;
    instr = 32'h0000007F; imem_ready = 1'b1; #1;
    total++; if (outs !== c_fetch) begin bad++; $display("FAIL ill_fetch got=%b want=%b", outs, c_fetch); end
    tick(); imem_ready = 1'b0; #1;
    total++; if (outs !== c_idle) begin bad++; $display("FAIL ill_decode got=%b want=%b", outs, c_idle); end
    tick();
    imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1;
    want = 17'b000000_00_00_00_00_1_01;
    for (int i = 0; i < 20; i++) begin
      #1;
      total++; if (outs !== want) begin bad++; $display("FAIL ill_trap%0d got=%b want=%b", i, outs, want); end
      tick();
    end
    do_reset();
    total++; if (outs !== c_req) begin bad++; $display("FAIL ill_after_reset got=%b want=%b", outs, c_req); end
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL ill_retired got=%0d want=0", retired); end
  endtask

  task automatic test_imem_timeout;
    for (int i = 0; i < 8; i++) begin
      imem_ready = 1'b0; #1;
      total++; if (outs !== c_req) begin bad++; $display("FAIL ito_wait%0d got=%b want=%b", i, outs, c_req); end
      tick();
    end
    want = 17'b000000_00_00_00_00_1_10;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (outs !== want) begin bad++; $display("FAIL ito_trap%0d got=%b want=%b", i, outs, want); end
      tick();
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw();
    test_branch();
    test_jal();
    test_store();
    test_lui();
    test_fetch_limit_ready();
    test_dmem_timeout();
    test_illegal();
    test_imem_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
